// File: rtl/weight_ram_controller.sv
// Weight RAM sequencer: streams weights/biases into a banked RAM (one bank per feature),
// then walks the filters in order, presenting each filter's bank outputs under valid/consume.
module weight_ram_controller #(
    parameter int Bit_width            = 8,
    parameter int Nr_depth             = 8,
    parameter int Depth_counter_bits   = 3,
    parameter int Nr_feature           = 6,
    parameter int Feature_counter_bits = 3
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            Load_start,
    input  logic                            In_valid,
    input  logic [Bit_width-1:0]            In_data,
    output logic                            In_ready,
    output logic                            Loaded,
    output logic                            Load_done,
    input  logic                            Run_start,
    output logic                            Weights_valid,
    output logic [Depth_counter_bits-1:0]   Filter_index,
    input  logic                            Filter_consume,
    output logic                            Run_done,
    output logic                            Ram_write_en,
    output logic [Feature_counter_bits-1:0] Ram_addr_width_write,
    output logic [Depth_counter_bits-1:0]   Ram_addr_depth_write,
    output logic [Bit_width-1:0]            Ram_write_data,
    output logic                            Ram_read_en,
    output logic [Depth_counter_bits-1:0]   Ram_addr_depth_read
);

    localparam logic [Depth_counter_bits-1:0]   LAST_D = Depth_counter_bits'(Nr_depth - 1);
    localparam logic [Feature_counter_bits-1:0] LAST_F = Feature_counter_bits'(Nr_feature - 1);
    localparam logic [Depth_counter_bits-1:0]   ONE_D  = Depth_counter_bits'(1);
    localparam logic [Feature_counter_bits-1:0] ONE_F  = Feature_counter_bits'(1);
    localparam logic [Depth_counter_bits-1:0]   ZERO_D = '0;
    localparam logic [Feature_counter_bits-1:0] ZERO_F = '0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_READY   = 3'd2,
        S_FETCH   = 3'd3,
        S_PRESENT = 3'd4
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [Depth_counter_bits-1:0]   r_depth;
    logic [Depth_counter_bits-1:0]   w_depth_next;
    logic [Feature_counter_bits-1:0] r_feature;
    logic [Feature_counter_bits-1:0] w_feature_next;

    logic                            w_accept;
    logic                            w_last_beat;
    logic                            w_last_consume;

    logic                            w_in_ready;
    logic                            w_loaded;
    logic                            w_load_done;
    logic                            w_weights_valid;
    logic [Depth_counter_bits-1:0]   w_filter_index;
    logic                            w_run_done;
    logic                            w_write_en;
    logic [Feature_counter_bits-1:0] w_addr_width_write;
    logic [Depth_counter_bits-1:0]   w_addr_depth_write;
    logic [Bit_width-1:0]            w_write_data;
    logic                            w_read_en;
    logic [Depth_counter_bits-1:0]   w_addr_depth_read;

    // In_ready is high exactly while in LOAD, so it doubles as the stream handshake qualifier.
    assign w_accept       = (r_state == S_LOAD) && In_valid && In_ready;
    assign w_last_beat    = w_accept && (r_depth == LAST_D) && (r_feature == LAST_F);
    assign w_last_consume = (r_state == S_PRESENT) && Filter_consume && (r_depth == LAST_D);

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; Load_start takes priority over Run_start in READY
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Load_start) begin
                    w_state_next = S_LOAD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_LOAD: begin
                if (w_last_beat) begin
                    w_state_next = S_READY;
                end else begin
                    w_state_next = S_LOAD;
                end
            end
            S_READY: begin
                if (Load_start) begin
                    w_state_next = S_LOAD;
                end else if (Run_start) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_READY;
                end
            end
            S_FETCH: begin
                w_state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (w_last_consume) begin
                    w_state_next = S_READY;
                end else if (Filter_consume) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_PRESENT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Filter (depth) and bank (feature) counters; load order is filter-major
    always_comb begin
        w_depth_next   = r_depth;
        w_feature_next = r_feature;
        case (r_state)
            S_IDLE: begin
                if (Load_start) begin
                    w_depth_next   = ZERO_D;
                    w_feature_next = ZERO_F;
                end else begin
                    w_depth_next   = r_depth;
                    w_feature_next = r_feature;
                end
            end
            S_LOAD: begin
                if (w_accept && (r_feature == LAST_F)) begin
                    w_depth_next   = r_depth + ONE_D;
                    w_feature_next = ZERO_F;
                end else if (w_accept) begin
                    w_depth_next   = r_depth;
                    w_feature_next = r_feature + ONE_F;
                end else begin
                    w_depth_next   = r_depth;
                    w_feature_next = r_feature;
                end
            end
            S_READY: begin
                if (Load_start) begin
                    w_depth_next   = ZERO_D;
                    w_feature_next = ZERO_F;
                end else if (Run_start) begin
                    w_depth_next   = ZERO_D;
                    w_feature_next = r_feature;
                end else begin
                    w_depth_next   = r_depth;
                    w_feature_next = r_feature;
                end
            end
            S_PRESENT: begin
                if (w_last_consume) begin
                    w_depth_next = ZERO_D;
                end else if (Filter_consume) begin
                    w_depth_next = r_depth + ONE_D;
                end else begin
                    w_depth_next = r_depth;
                end
            end
            default: begin
                w_depth_next   = r_depth;
                w_feature_next = r_feature;
            end
        endcase
    end

    // Counter registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_depth   <= ZERO_D;
            r_feature <= ZERO_F;
        end else begin
            r_depth   <= w_depth_next;
            r_feature <= w_feature_next;
        end
    end

    // Output decode: next-cycle values of every registered output, keyed off the next state
    always_comb begin
        w_in_ready      = (w_state_next == S_LOAD);
        w_loaded        = (w_state_next == S_READY) || (w_state_next == S_FETCH) ||
                          (w_state_next == S_PRESENT);
        w_load_done     = w_last_beat;
        w_run_done      = w_last_consume;
        w_write_en      = w_accept;
        w_read_en       = (w_state_next == S_FETCH);
        w_weights_valid = (w_state_next == S_PRESENT);
        if (w_accept) begin
            w_addr_width_write = r_feature;
            w_addr_depth_write = r_depth;
            w_write_data       = In_data;
        end else begin
            w_addr_width_write = Ram_addr_width_write;
            w_addr_depth_write = Ram_addr_depth_write;
            w_write_data       = Ram_write_data;
        end
        if (w_state_next == S_FETCH) begin
            w_addr_depth_read = w_depth_next;
        end else begin
            w_addr_depth_read = Ram_addr_depth_read;
        end
        if (w_state_next == S_PRESENT) begin
            w_filter_index = w_depth_next;
        end else begin
            w_filter_index = Filter_index;
        end
    end

    // Output registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            In_ready             <= 1'b0;
            Loaded               <= 1'b0;
            Load_done            <= 1'b0;
            Weights_valid        <= 1'b0;
            Filter_index         <= ZERO_D;
            Run_done             <= 1'b0;
            Ram_write_en         <= 1'b0;
            Ram_addr_width_write <= ZERO_F;
            Ram_addr_depth_write <= ZERO_D;
            Ram_write_data       <= {Bit_width{1'b0}};
            Ram_read_en          <= 1'b0;
            Ram_addr_depth_read  <= ZERO_D;
        end else begin
            In_ready             <= w_in_ready;
            Loaded               <= w_loaded;
            Load_done            <= w_load_done;
            Weights_valid        <= w_weights_valid;
            Filter_index         <= w_filter_index;
            Run_done             <= w_run_done;
            Ram_write_en         <= w_write_en;
            Ram_addr_width_write <= w_addr_width_write;
            Ram_addr_depth_write <= w_addr_depth_write;
            Ram_write_data       <= w_write_data;
            Ram_read_en          <= w_read_en;
            Ram_addr_depth_read  <= w_addr_depth_read;
        end
    end

endmodule

// File: tb/tb_weight_ram_controller.sv
// Randomised bench for weight_ram_controller: a beat/filter-count reference model, a small
// negedge-sampled RAM, and a per-cycle comparator, plus directed scenarios with literal checks.
module tb_weight_ram_controller;

    localparam int BW = 8, ND = 8, DCB = 3, NF = 6, FCB = 3, NB = ND * NF, LOGN = 4096;
    localparam int M_IDLE = 0, M_LOAD = 1, M_READY = 2, M_FETCH = 3, M_PRESENT = 4;

    logic           Clk = 1'b0, Rst = 1'b1;
    logic           Load_start = 1'b0, In_valid = 1'b0, Run_start = 1'b0, Filter_consume = 1'b0;
    logic [BW-1:0]  In_data = '0;
    logic           In_ready, Loaded, Load_done, Weights_valid, Run_done, Ram_write_en, Ram_read_en;
    logic [DCB-1:0] Filter_index, Ram_addr_depth_write, Ram_addr_depth_read;
    logic [FCB-1:0] Ram_addr_width_write;
    logic [BW-1:0]  Ram_write_data;

    weight_ram_controller #(.Bit_width(BW), .Nr_depth(ND), .Depth_counter_bits(DCB),
                            .Nr_feature(NF), .Feature_counter_bits(FCB)) dut (
        .Clk(Clk), .Rst(Rst), .Load_start(Load_start), .In_valid(In_valid), .In_data(In_data),
        .In_ready(In_ready), .Loaded(Loaded), .Load_done(Load_done), .Run_start(Run_start),
        .Weights_valid(Weights_valid), .Filter_index(Filter_index),
        .Filter_consume(Filter_consume), .Run_done(Run_done), .Ram_write_en(Ram_write_en),
        .Ram_addr_width_write(Ram_addr_width_write), .Ram_addr_depth_write(Ram_addr_depth_write),
        .Ram_write_data(Ram_write_data), .Ram_read_en(Ram_read_en),
        .Ram_addr_depth_read(Ram_addr_depth_read));

    always #5 Clk = ~Clk;

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({In_ready, Loaded, Load_done, Weights_valid, Filter_index, Run_done,
                    Ram_write_en, Ram_addr_width_write, Ram_addr_depth_write, Ram_write_data,
                    Ram_read_en, Ram_addr_depth_read});
    endfunction

    // Reference model: tracks beats accepted and the filter being served
    int            m_mode = M_IDLE, m_beats = 0, m_filt = 0;
    logic [BW-1:0] golden [0:NB-1];
    int            e_in_ready = 0, e_loaded = 0, e_load_done = 0, e_wr = 0, e_wr_d = 0, e_wr_f = 0;
    int            e_wr_data = 0, e_rd = 0, e_rd_d = 0, e_wv = 0, e_run_done = 0;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_mode = M_IDLE; m_beats = 0; m_filt = 0;
            e_in_ready = 0; e_loaded = 0; e_load_done = 0; e_wr = 0; e_wr_d = 0; e_wr_f = 0;
            e_wr_data = 0; e_rd = 0; e_rd_d = 0; e_wv = 0; e_run_done = 0;
        end else begin
            e_wr = 0; e_load_done = 0; e_run_done = 0;
            case (m_mode)
                M_IDLE: if (Load_start) begin m_mode = M_LOAD; m_beats = 0; end
                M_LOAD: if (In_valid) begin
                    e_wr = 1; e_wr_d = m_beats / NF; e_wr_f = m_beats % NF; e_wr_data = int'(In_data);
                    golden[m_beats] = In_data;
                    m_beats++;
                    if (m_beats == NB) begin m_mode = M_READY; e_load_done = 1; end
                end
                M_READY: if (Load_start) begin m_mode = M_LOAD; m_beats = 0; end
                         else if (Run_start) begin m_mode = M_FETCH; m_filt = 0; end
                M_FETCH: m_mode = M_PRESENT;
                M_PRESENT: if (Filter_consume) begin
                    if (m_filt == ND - 1) begin m_mode = M_READY; e_run_done = 1; end
                    else begin m_filt++; m_mode = M_FETCH; end
                end
                default: m_mode = M_IDLE;
            endcase
            e_in_ready = (m_mode == M_LOAD);
            e_loaded   = (m_mode >= M_READY);
            e_rd       = (m_mode == M_FETCH);
            e_rd_d     = m_filt;
            e_wv       = (m_mode == M_PRESENT);
        end
    end

    // RAM behaviour: samples strobes on the falling edge
    logic [BW-1:0] mem  [0:NF-1][0:ND-1];
    logic [BW-1:0] rd_q [0:NF-1];
    always @(negedge Clk) begin
        if (Ram_write_en && int'(Ram_addr_width_write) < NF)
            mem[Ram_addr_width_write][Ram_addr_depth_write] <= Ram_write_data;
        if (Ram_read_en) for (int b = 0; b < NF; b++) rd_q[b] <= mem[b][Ram_addr_depth_read];
    end

    int             n_wr = 0, n_rd = 0, n_ld = 0, n_run = 0, n_f3 = 0;
    logic [DCB-1:0] wlog_d [0:LOGN-1];
    logic [FCB-1:0] wlog_f [0:LOGN-1];
    logic [BW-1:0]  wlog_v [0:LOGN-1];

    always @(negedge Clk) begin
        chk("in_ready", 32'(In_ready), e_in_ready);
        chk("loaded", 32'(Loaded), e_loaded);
        chk("load_done", 32'(Load_done), e_load_done);
        chk("write_en", 32'(Ram_write_en), e_wr);
        chk("read_en", 32'(Ram_read_en), e_rd);
        chk("weights_valid", 32'(Weights_valid), e_wv);
        chk("run_done", 32'(Run_done), e_run_done);
        chk("wr_rd_exclusive", 32'(Ram_write_en & Ram_read_en), 0);
        if (e_wr != 0) begin
            chk("wr_depth", 32'(Ram_addr_depth_write), e_wr_d);
            chk("wr_bank", 32'(Ram_addr_width_write), e_wr_f);
            chk("wr_data", 32'(Ram_write_data), e_wr_data);
        end
        if (e_rd != 0) chk("rd_depth", 32'(Ram_addr_depth_read), e_rd_d);
        if (e_wv != 0) begin
            chk("filter_index", 32'(Filter_index), m_filt);
            for (int b = 0; b < NF; b++) chk("weight", 32'(rd_q[b]), 32'(golden[m_filt * NF + b]));
        end
        if (Ram_write_en) begin
            if (n_wr < LOGN) begin
                wlog_d[n_wr] = Ram_addr_depth_write;
                wlog_f[n_wr] = Ram_addr_width_write;
                wlog_v[n_wr] = Ram_write_data;
            end
            n_wr++;
        end
        if (Ram_read_en) n_rd++;
        if (Load_done) n_ld++;
        if (Run_done) n_run++;
        if (Weights_valid && Filter_index == 3'd3) n_f3++;
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic start_load(input bit with_run);
        tick; Load_start = 1'b1; Run_start = with_run;
        tick; Load_start = 1'b0; Run_start = 1'b0;
    endtask

    // mode 0: valid always, 1: valid every other cycle, 2: random valid/data and ignored controls
    task automatic load_beats(input int mode, input int stop);
        int k = 0, cyc = 0;
        bit v;
        while (k < stop && cyc < 600) begin
            tick;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            In_valid = v;
            In_data  = (mode == 2) ? BW'($urandom) : BW'((k / NF) * 16 + (k % NF));
            if (mode == 2) begin
                Load_start     = ($urandom_range(0, 3) == 0);
                Run_start      = ($urandom_range(0, 3) == 0);
                Filter_consume = ($urandom_range(0, 1) == 0);
            end
            if (v && In_ready) k++;
            cyc++;
        end
        chk("load_progress", k, stop);
        tick;
        In_valid = 1'b0; Load_start = 1'b0; Run_start = 1'b0; Filter_consume = 1'b0;
    endtask

    // mode 0: consume held high, 1: filter 3 presented for five cycles, 2: random consume
    task automatic do_run(input int mode, input int stop_at);
        int cyc = 0, hold = 0;
        bit done = 0;
        tick; Run_start = 1'b1;
        tick; Run_start = 1'b0;
        Filter_consume = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!done && cyc < 400) begin
            tick; cyc++;
            if (Run_done) done = 1;
            else if (stop_at >= 0 && Weights_valid && int'(Filter_index) == stop_at) done = 1;
            else if (mode == 1 && Weights_valid && Filter_index == 3'd3 && hold < 4) begin
                Filter_consume = 1'b0; hold++;
            end else if (mode == 2) Filter_consume = ($urandom_range(0, 2) != 0);
            else Filter_consume = 1'b1;
        end
        chk("run_finished", 32'(done), 1);
        Filter_consume = 1'b0;
    endtask

    task automatic reset_now();
        In_valid = 1'b0; Load_start = 1'b0; Run_start = 1'b0; Filter_consume = 1'b0;
        Rst = 1'b1;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        tick; tick;
        Rst = 1'b0;
        chk("reset_loaded", 32'(Loaded), 0);
    endtask

    initial begin
        int w0, l0, r0, d0, f0;
        repeat (3) tick;
        chk("reset_outputs", all_outs(), 0);
        Rst = 1'b0;

        r0 = n_rd;
        tick; Run_start = 1'b1; tick; Run_start = 1'b0; repeat (3) tick;
        chk("idle_run_ignored", n_rd - r0, 0);
        chk("idle_in_ready", 32'(In_ready), 0);

        w0 = n_wr; l0 = n_ld;
        start_load(1'b0); load_beats(0, NB); tick;
        chk("load_strobes", n_wr - w0, NB);
        chk("load_done_pulses", n_ld - l0, 1);
        chk("beat7_bank", 32'(wlog_f[w0 + 7]), 1);
        chk("beat7_entry", 32'(wlog_d[w0 + 7]), 1);
        chk("beat7_data", 32'(wlog_v[w0 + 7]), 32'h11);
        chk("loaded_after_load", 32'(Loaded), 1);

        w0 = n_wr; l0 = n_ld;
        start_load(1'b0); load_beats(1, NB); tick;
        chk("toggle_load_strobes", n_wr - w0, NB);
        chk("toggle_load_done", n_ld - l0, 1);

        r0 = n_rd; d0 = n_run;
        do_run(0, -1); tick;
        chk("run_reads", n_rd - r0, ND);
        chk("run_done_pulses", n_run - d0, 1);
        chk("run_back_ready", 32'(Loaded & ~Weights_valid), 1);

        r0 = n_rd; f0 = n_f3;
        do_run(1, -1); tick;
        chk("delay_run_reads", n_rd - r0, ND);
        chk("filter3_window", n_f3 - f0, 5);

        r0 = n_rd;
        start_load(1'b1);
        chk("both_start_in_ready", 32'(In_ready), 1);
        chk("both_start_loaded", 32'(Loaded), 0);
        chk("both_start_no_read", n_rd - r0, 0);
        load_beats(2, NB); tick;

        start_load(1'b0); load_beats(0, 20); tick;
        reset_now();
        r0 = n_rd;
        tick; Run_start = 1'b1; tick; Run_start = 1'b0; repeat (2) tick;
        chk("post_reset_run_ignored", n_rd - r0, 0);

        start_load(1'b0); load_beats(2, NB); tick;
        do_run(0, 5);
        chk("stopped_at_filter5", 32'(Filter_index), 5);
        reset_now();

        for (int i = 0; i < 3; i++) begin
            w0 = n_wr; d0 = n_run;
            start_load(1'b0); load_beats(2, NB); tick;
            chk("rand_load_strobes", n_wr - w0, NB);
            do_run(2, -1); tick;
            chk("rand_run_done", n_run - d0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/weight_ram_controller.md
Name: weight_ram_controller

Overview:
Sequencer for the per-filter weight RAM (one bank per feature, Nr_depth entries each). Accepts a serial valid/ready stream of weights and biases, generates the RAM write strobes, bank select and entry addresses, then walks the filters in order, issuing one RAM read per filter. Each filter's Nr_feature values are presented to the convolution datapath under a valid/consume handshake. Sits between the host/DMA loader and the compute engine. The RAM is driven directly by this block's outputs.

Parameters:
Bit_width, 8, bits per weight/bias value
Nr_depth, 8, number of filters (RAM entries per bank)
Depth_counter_bits, 3, filter-index width; 2**Depth_counter_bits == Nr_depth
Nr_feature, 6, weights+bias per filter (number of RAM banks)
Feature_counter_bits, 3, bank-select width; 2**Feature_counter_bits >= Nr_feature

Ports:
Clk  in  1  clock, posedge; RAM samples on negedge of same clock
Rst  in  1  reset, asynchronous, active-high
Load_start  in  1  begin a full weight load
In_valid  in  1  stream beat valid
In_data  in  Bit_width  stream value
In_ready  out  1  controller accepts beat
Loaded  out  1  RAM holds a complete weight set
Load_done  out  1  one-cycle pulse, load finished
Run_start  in  1  begin walking filters 0..Nr_depth-1
Weights_valid  out  1  RAM read outputs hold filter Filter_index
Filter_index  out  Depth_counter_bits  filter currently presented
Filter_consume  in  1  consumer finished current filter
Run_done  out  1  one-cycle pulse, last filter consumed
Ram_write_en  out  1  RAM write strobe
Ram_addr_width_write  out  Feature_counter_bits  bank select (feature index)
Ram_addr_depth_write  out  Depth_counter_bits  entry (filter index) for write
Ram_write_data  out  Bit_width  write data
Ram_read_en  out  1  RAM read strobe
Ram_addr_depth_read  out  Depth_counter_bits  entry for read

Behaviour:
- All outputs are registered. Reset: state IDLE, all outputs 0, counters 0. Reset mid-operation aborts at once and RAM contents are disregarded (Loaded=0 until the next full load).
- States: IDLE, LOAD, READY, FETCH, PRESENT.
- IDLE: In_ready=0. Load_start -> LOAD (d=0, f=0). Run_start is ignored.
- LOAD: In_ready=1. A beat is accepted when In_valid&&In_ready at posedge t.
  - Cycle t+1: Ram_write_en=1, Ram_addr_depth_write=d, Ram_addr_width_write=f, Ram_write_data=In_data. RAM captures it on that cycle's negedge.
  - Order is filter-major: f increments; at f==Nr_feature-1, f wraps to 0 and d increments.
  - Accepting beat (Nr_depth-1, Nr_feature-1) moves to READY. In_ready drops in the following cycle. Loaded=1 and Load_done=1 for one cycle, coincident with the final write strobe.
  - Load_start, Run_start and Filter_consume are ignored in LOAD. In_valid gaps simply stall.
- READY: Loaded=1.
  - Load_start -> LOAD and clears Loaded.
  - Run_start -> FETCH with d=0.
  - If Load_start and Run_start arrive together, Load_start wins.
- FETCH (1 cycle): Ram_read_en=1, Ram_addr_depth_read=d, then -> PRESENT. RAM outputs settle after the negedge of the FETCH cycle.
- PRESENT: Weights_valid=1, Filter_index=d. Ram_read_en=0, so RAM outputs hold.
  - Filter_consume at last filter (d==Nr_depth-1): -> READY with a Run_done pulse next cycle and Weights_valid=0.
  - Filter_consume otherwise: d+1 -> FETCH and Weights_valid=0.
  - Filter_consume asserted outside PRESENT is ignored.
- Throughput: 2 cycles per filter minimum. Load takes Nr_depth*Nr_feature accepted beats.
- Ram_write_en and Ram_read_en are never high in the same cycle.

Test Plan:
- Reset, then load 48 beats with In_data=d*16+f, In_valid always 1 -> 48 write strobes; beat 7 writes bank 1, entry 1, value 0x11; Load_done is a single pulse on the 48th strobe; Loaded=1.
- Load with In_valid toggling every other cycle -> exactly 48 strobes, order and addresses unchanged, no duplicate writes.
- Run_start after load, Filter_consume held high -> Ram_read_en at addresses 0..7 every 2nd cycle; Weights_valid windows show Filter_index 0..7; Run_done pulses once; back in READY.
- Consumer delays Filter_consume 5 cycles on filter 3 -> Weights_valid and Filter_index=3 held for 5 cycles; no extra read strobe.
- Load_start and Run_start together in READY -> enters LOAD, Loaded=0, no read strobe. Run_start in IDLE -> no response.
- Assert Rst during LOAD at beat 20 and during PRESENT at filter 5 -> all outputs 0 asynchronously; IDLE, Loaded=0; a fresh full load then succeeds.
